// File: rtl/lockin_amplifier.sv
// ---------------------------------------------------------------------------
// lockin_amplifier
//
// Quadrature reference generator for the lock-in / PLL datapath. It measures
// the period and high time of the 1-bit reference signal_in. Once two
// consecutive period measurements agree within TOL, it regenerates the
// reference on signal_out, delayed by a quarter period (90 degree lag). The
// feedback loop in feedback_lockin_amplifier consumes signal_out.
//
// Parameters
//   CNT_W      width of the phase, period and high-time counters (saturating)
//   MIN_PERIOD smallest period, in clocks, accepted as a valid measurement
//   TOL        largest |P - P_lat|, in clocks, that still counts as stable
//
// Ports
//   clk        system clock, all state changes on the rising edge
//   reset_n    synchronous active-low reset
//   signal_in  asynchronous 1-bit reference input
//   signal_out registered quadrature output, 0 while not locked
//
// Acquisition state, held in two flags:
//   seen_edge | locked | meaning
//   ----------+--------+-----------------------------------------------------
//       0     |   0    | waiting for the first rising edge (nothing to time)
//       1     |   0    | timing periods, no stable measurement yet
//       1     |   1    | period stable, signal_out follows the window
// ---------------------------------------------------------------------------
module lockin_amplifier #(
    parameter int CNT_W      = 16,
    parameter int MIN_PERIOD = 4,
    parameter int TOL        = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic signal_in,
    output logic signal_out
);

    localparam logic [CNT_W-1:0] C_MAX = '1;
    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_TOL = CNT_W'(TOL);
    localparam logic [CNT_W:0]   C_MIN = (CNT_W+1)'(MIN_PERIOD);

    // Input synchronizer and edge history
    logic             r_sync1;
    logic             r_sync2;
    logic             r_prev;

    // Counters and latched measurements
    logic [CNT_W-1:0] r_ph;
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_p_lat;
    logic [CNT_W-1:0] r_h_lat;

    // Acquisition flags
    logic             r_seen_edge;
    logic             r_locked;

    // Combinational helpers
    logic             w_rise;
    logic             w_ph_sat;
    logic [CNT_W-1:0] w_p_meas;
    logic             w_valid;
    logic [CNT_W-1:0] w_diff;
    logic             w_stable;
    logic [CNT_W-1:0] w_h_clip;
    logic [CNT_W-1:0] w_q;
    logic [CNT_W:0]   w_q_x;
    logic [CNT_W:0]   w_e;
    logic [CNT_W:0]   w_p_lat_x;
    logic [CNT_W:0]   w_ph_x;
    logic             w_win;
    logic             w_lost;

    assign w_rise   = r_sync2 & ~r_prev;
    assign w_ph_sat = (r_ph == C_MAX);

    // ph holds clocks since the last detect cycle minus one, so the period
    // ending on this detect cycle is ph + 1.
    assign w_p_meas = w_ph_sat ? C_MAX : (r_ph + C_ONE);
    assign w_valid  = ({1'b0, w_p_meas} >= C_MIN) && !w_ph_sat;

    assign w_diff   = (w_p_meas >= r_p_lat) ? (w_p_meas - r_p_lat)
                                            : (r_p_lat - w_p_meas);
    assign w_stable = (r_p_lat != '0) && (w_diff <= C_TOL);

    // A high time longer than the period can only come from a stuck-high
    // input; clip it so the window never covers more than one period.
    assign w_h_clip = (r_hcnt < w_p_meas) ? r_hcnt : w_p_meas;

    // Window arithmetic runs one bit wider so Q + H_lat and 2*P_lat never
    // overflow.
    assign w_q       = r_p_lat >> 2;
    assign w_q_x     = {1'b0, w_q};
    assign w_e       = w_q_x + {1'b0, r_h_lat};
    assign w_p_lat_x = {1'b0, r_p_lat};
    assign w_ph_x    = {1'b0, r_ph};

    always_comb begin
        w_win = 1'b0;
        if (w_e < w_p_lat_x) begin
            w_win = (w_ph_x >= w_q_x) && (w_ph_x < w_e);
        end else begin
            // The high interval runs past the end of the period and wraps
            // to the start of the next one.
            w_win = (w_ph_x >= w_q_x) || (w_ph_x < (w_e - w_p_lat_x));
        end
    end

    assign w_lost = r_locked && (w_ph_x > {r_p_lat, 1'b0});

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_prev      <= 1'b0;
            r_ph        <= '0;
            r_hcnt      <= '0;
            r_p_lat     <= '0;
            r_h_lat     <= '0;
            r_seen_edge <= 1'b0;
            r_locked    <= 1'b0;
            signal_out  <= 1'b0;
        end else begin
            r_sync1 <= signal_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;

            // Uses the pre-update lock flag and window, so a detect cycle
            // never sees the freshly latched period.
            signal_out <= r_locked & w_win;

            if (w_rise) begin
                r_ph   <= '0;
                r_hcnt <= C_ONE;
            end else begin
                if (!w_ph_sat) begin
                    r_ph <= r_ph + C_ONE;
                end
                if (r_sync2 && (r_hcnt != C_MAX)) begin
                    r_hcnt <= r_hcnt + C_ONE;
                end
            end

            // A detect cycle outranks loss of signal in the same clock.
            if (w_rise) begin
                if (!r_seen_edge) begin
                    r_seen_edge <= 1'b1;
                end else if (w_valid) begin
                    r_locked <= w_stable;
                    r_p_lat  <= w_p_meas;
                    r_h_lat  <= w_h_clip;
                end else begin
                    r_locked <= 1'b0;
                    r_p_lat  <= '0;
                end
            end else if (w_lost) begin
                // No edge for two periods: forget everything so relock has
                // to start again from three fresh edges.
                r_locked    <= 1'b0;
                r_p_lat     <= '0;
                r_seen_edge <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lockin_amplifier.sv
// ---------------------------------------------------------------------------
// tb_lockin_amplifier
//
// Directed bench for lockin_amplifier. signal_in is driven one clock at a
// time, right after each rising edge; signal_out is sampled 1 ns after the
// following edge. For a period driven with its rise at step k = 0, bit k of
// the captured word is signal_out after the (k+1)-th edge, which corresponds
// to ph = k - 3 of that period once the DUT has locked. Expected words are
// worked out by hand from the period, high time and window Q..Q+H_lat.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lockin_amplifier;

    logic        clk       = 1'b0;
    logic        reset_n   = 1'b0;
    logic        signal_in = 1'b0;
    logic        signal_out;

    int          total = 0;
    int          bad   = 0;
    logic [63:0] o;

    lockin_amplifier #(
        .CNT_W      (16),
        .MIN_PERIOD (4),
        .TOL        (1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .signal_in  (signal_in),
        .signal_out (signal_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive n clocks, the first h of them high; capture signal_out per clock.
    task automatic drive(input int h, input int n, output logic [63:0] outs);
        outs = '0;
        for (int k = 0; k < n; k++) begin
            signal_in = (k < h);
            @(posedge clk);
            #1;
            outs[k] = signal_out;
        end
    endtask

    task automatic per(input string tag, input int p, input int h, input logic [31:0] exp);
        drive(h, p, o);
        chk(tag, o[31:0], exp);
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        signal_in = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        reset_n = 1'b1;
        drive(0, 4, o);
    endtask

    initial begin
        // Power-on reset
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("rst_hold", signal_out, 0);
        end
        reset_n = 1'b1;
        drive(0, 4, o);
        chk("rst_idle", o[31:0], 0);

        // 50% duty, period 16: Q=4, H_lat=8 -> ph 4..11 -> k 7..14
        per("p16_1", 16, 8, 32'h0);
        per("p16_2", 16, 8, 32'h0);
        per("p16_3", 16, 8, 32'h7F80);
        per("p16_4", 16, 8, 32'h7F80);
        chk("p16_cnt", $countones(o), 8);

        // Reset in the middle of a high phase while signal_in toggles
        drive(8, 9, o);
        chk("p16_part", o[31:0], 32'h180);
        reset_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i % 3 == 0) signal_in = ~signal_in;
            @(posedge clk);
            #1;
            chk("rst_mid", signal_out, 0);
        end
        reset_n   = 1'b1;
        signal_in = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_rel", signal_out, 0);
        drive(0, 4, o);
        chk("rst_rel_idle", o[31:0], 0);

        // Relock needs three fresh edges after reset
        per("rl_1", 16, 8, 32'h0);
        per("rl_2", 16, 8, 32'h0);
        per("rl_3", 16, 8, 32'h7F80);
        per("rl_4", 16, 8, 32'h7F80);

        // Period step 16 -> 24 (high 12): old window, drop, relock with Q=6
        per("s24_1", 24, 12, 32'h7F80);
        per("s24_2", 24, 12, 32'h0);
        per("s24_3", 24, 12, 32'h1FFE00);
        per("s24_4", 24, 12, 32'h1FFE00);
        chk("s24_cnt", $countones(o), 12);

        // 25% duty, period 20: Q=5, H_lat=5 -> ph 5..9 -> k 8..12
        do_reset();
        per("p20_1", 20, 5, 32'h0);
        per("p20_2", 20, 5, 32'h0);
        per("p20_3", 20, 5, 32'h1F00);
        per("p20_4", 20, 5, 32'h1F00);
        chk("p20_cnt", $countones(o), 5);

        // Wrap: period 12, high 10 -> Q=3, E=13 -> ph 0 and 3..11
        do_reset();
        per("wr_1", 12, 10, 32'h0);
        per("wr_2", 12, 10, 32'h0);
        per("wr_3", 12, 10, 32'hFC8);
        per("wr_4", 12, 10, 32'hFCF);
        chk("wr_cnt", $countones(o), 10);

        // Jitter: alternating 16/17 stays locked with TOL=1
        do_reset();
        per("jit_1", 16, 8, 32'h0);
        per("jit_2", 17, 8, 32'h0);
        per("jit_3", 16, 8, 32'h7F80);
        per("jit_4", 17, 8, 32'h7F80);
        per("jit_5", 16, 8, 32'h7F80);
        per("jit_6", 17, 8, 32'h7F80);

        // Period 3 is below MIN_PERIOD and must never lock
        do_reset();
        for (int i = 0; i < 8; i++) begin
            per("p3", 3, 1, 32'h0);
        end

        // Stop while locked at P=16, high 14 (wrapping window keeps
        // signal_out high for every ph >= 4 until the loss of signal)
        do_reset();
        per("st_1", 16, 14, 32'h0);
        per("st_2", 16, 14, 32'h0);
        per("st_3", 16, 14, 32'hFF98);
        per("st_4", 16, 14, 32'hFF9F);
        drive(0, 40, o);
        // o[j] corresponds to ph = j + 13
        chk("st_hold_ph31", o[18], 1);
        chk("st_lost_ph35", o[22], 0);
        chk("st_lost_tail", o[39:23], 0);
        per("st_re1", 16, 8, 32'h0);
        per("st_re2", 16, 8, 32'h0);
        per("st_re3", 16, 8, 32'h7F80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lockin_amplifier.md
Name: lockin_amplifier

Overview:
- Single-bit quadrature reference generator for the lock-in/PLL datapath.
- Measures the period and high time of the 1-bit reference `signal_in`.
- Once the period is stable, regenerates the waveform on `signal_out` delayed by a quarter period (90° lag).
- Instantiated inside feedback_lockin_amplifier, whose feedback loop consumes `signal_out`.

Parameters:
- CNT_W, 16: width of the phase, period and high-time counters; all saturate at 2^CNT_W-1.
- MIN_PERIOD, 4: smallest period in clocks accepted as valid.
- TOL, 1: maximum |P - P_lat| in clocks for a period to count as stable.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- signal_in  input  1  asynchronous 1-bit reference input.
- signal_out  output  1  registered quadrature output (90° lag), 0 when not locked.

Behaviour:
- Reset (reset_n low at a clk edge):
  - clears sync1, sync2, prev, ph, P_lat, H_lat, hcnt, seen_edge, locked and signal_out to 0.
  - Takes priority over all other activity, including mid-period.
- Input path:
  - Two-flop synchronizer: sync1 <= signal_in, sync2 <= sync1.
  - prev <= sync2.
  - rise = sync2 & ~prev (the "detect cycle").
- Phase counter ph (CNT_W bits):
  - Loads 0 on a detect cycle.
  - Otherwise increments, saturating at all-ones.
  - ph = clocks since the last detect cycle.
- High counter hcnt:
  - On a detect cycle, loads 1.
  - Otherwise increments (saturating) while sync2 = 1.
- On a detect cycle:
  - seen_edge = 0: set seen_edge; no measurement taken.
  - seen_edge = 1: P = ph + 1 (saturating) and H = hcnt.
  - valid = (P >= MIN_PERIOD) and ph not saturated.
  - If valid:
    - locked <= (P_lat != 0) and |P - P_lat| <= TOL.
    - P_lat <= P; H_lat <= min(H, P).
  - If not valid: locked <= 0, P_lat <= 0.
  - Result: first lock occurs on the 3rd detected rising edge after reset, given a steady input.
- Loss of signal:
  - When locked and ph > 2*P_lat (no edge for two periods), locked <= 0.
  - P_lat <= 0 and seen_edge <= 0, so relock needs three fresh edges.
- Window (combinational, from latched values):
  - Q = P_lat >> 2 (floor) and E = Q + H_lat.
  - If E < P_lat: win = (ph >= Q) and (ph < E).
  - Else (wraps): win = (ph >= Q) or (ph < E - P_lat).
- Output:
  - signal_out <= locked & win (registered).
  - Rising edge of signal_out occurs Q+1 clocks after the detect cycle; high for H_lat clocks per period.
  - Total lag from a signal_in rise = 2-3 sync clocks + 1 + Q.
- Simultaneous events:
  - A detect cycle and the loss-of-signal condition in the same cycle: the detect-cycle update wins.
  - The lock update and signal_out on a detect cycle both use the pre-update P_lat/H_lat.
- Arithmetic: unsigned throughout; comparisons use CNT_W+1 bits to avoid overflow in Q+H_lat and 2*P_lat.

Test Plan:
- Reset: hold reset_n low 5 clocks while toggling signal_in every 3 clocks -> signal_out = 0 throughout and 1 clock after release; nothing locked.
- 50% duty, period 16 (8 high/8 low):
  - locked after the 3rd detect cycle.
  - Afterwards signal_out is a period-16 square wave, high 8 clocks, rising 5 clocks after each detect cycle (ph 4..11).
- 25% duty, period 20 (5 high): Q=5, H_lat=5 -> signal_out high for ph 5..9, exactly 5 clocks per period.
- Wrap: period 12, 10 high -> Q=3, E=13 -> signal_out high for ph 0 and 3..11, i.e. 10 clocks per period.
- Period step 16 -> 24:
  - locked drops at the first 24-clock edge (diff 8 > TOL) and signal_out goes 0.
  - Relocks at the next edge with the period-24 window (Q=6).
- Jitter/invalid/stop:
  - Alternating periods 16/17 stay locked (TOL=1).
  - Period 3 never locks (< MIN_PERIOD).
  - Holding signal_in low while locked at P=16 clears locked and signal_out once ph reaches 33.
